// File: rtl/mux_rr_sel_arbiter.sv
// Round-robin arbiter driving the 2-bit select of a downstream 4:1 channel mux.
// Define MUX_SEL_TIMEOUT_EN to bound each grant to HOLD_MAX cycles.
module mux_rr_sel_arbiter #(
    parameter int HOLD_MAX = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] i_req,
    input  logic       i_release,
    output logic [1:0] o_sel,
    output logic [3:0] o_grant,
    output logic       o_sel_valid,
    output logic       o_timeout
);

    if (HOLD_MAX < 1 || HOLD_MAX > 255) begin : g_bad_hold_max
        $error("HOLD_MAX must be in the range 1..255");
    end

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    state_t     r_state;
    logic [1:0] r_ptr;
    logic [1:0] r_sel;
    logic [3:0] r_grant;
    logic       r_sel_valid;

    logic [7:0] w_req_dbl;
    logic [3:0] w_req_rot;
    logic [1:0] w_offset;
    logic [1:0] w_winner;
    logic       w_any_req;
    logic       w_norm_exit;
    logic       w_force_exit;

    // Rotate the request vector so bit 0 is the channel at the priority pointer.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        w_req_dbl = {i_req, i_req};
        w_req_rot = w_req_dbl[r_ptr +: 4];
        w_offset  = 2'd3;
        if (w_req_rot[0])
            w_offset = 2'd0;
        else if (w_req_rot[1])
            w_offset = 2'd1;
        else if (w_req_rot[2])
            w_offset = 2'd2;
        w_winner    = r_ptr + w_offset;
        w_any_req   = |i_req;
        w_norm_exit = i_release | ~i_req[r_sel];
    end

`ifdef MUX_SEL_TIMEOUT_EN
    localparam int CW = $clog2(HOLD_MAX + 1);

    logic [CW-1:0] r_hold;
    logic          r_timeout;

    // r_hold counts completed BUSY cycles, so the last allowed cycle sees HOLD_MAX-1.
    assign w_force_exit = ~w_norm_exit && (r_hold == CW'(HOLD_MAX - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hold    <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_timeout <= (r_state == ST_BUSY) && w_force_exit;
            if (r_state == ST_BUSY && !w_norm_exit && !w_force_exit)
                r_hold <= r_hold + 1'b1;
            else
                r_hold <= '0;
        end
    end

    assign o_timeout = r_timeout;
`else
    assign w_force_exit = 1'b0;
    assign o_timeout    = 1'b0;
`endif

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values of its neighbours.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_ptr       <= 2'd0;
            r_sel       <= 2'd0;
            r_grant     <= 4'b0000;
            r_sel_valid <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_grant     <= 4'b0000;
                    r_sel_valid <= 1'b0;
                    if (w_any_req) begin
                        r_sel       <= w_winner;
                        r_grant     <= 4'b0001 << w_winner;
                        r_sel_valid <= 1'b1;
                        r_state     <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    // r_sel is left alone on exit so the mux output stays stable.
                    if (w_norm_exit || w_force_exit) begin
                        r_grant     <= 4'b0000;
                        r_sel_valid <= 1'b0;
                        r_ptr       <= r_sel + 2'd1;
                        r_state     <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign o_sel       = r_sel;
    assign o_grant     = r_grant;
    assign o_sel_valid = r_sel_valid;

endmodule
